// File: rtl/packet_gen_pkg.sv
// Shared definitions for the test packet generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package packet_gen_pkg;

  localparam int DW_DEFAULT      = 512;
  localparam int MAX_LEN_DEFAULT = 9600;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/packet_gen_fill.sv
// Builds one beat of incrementing 16-bit pattern plus its byte enables.
// Latency: combinational.
// Backpressure: none; the caller decides when a beat is loaded.
module packet_gen_fill
  import packet_gen_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [15:0]             word,
  input  logic                    last,
  input  logic [$clog2(DW/8):0]   last_bytes,
  output logic [DW-1:0]           tdata,
  output logic [DW/8-1:0]         tkeep
);

  localparam int BPB = DW / 8;
  localparam int WPB = DW / 16;
  localparam int LBW = $clog2(BPB) + 1;

  // Word k of the beat is base+k (wrapping); only the last beat trims TKEEP.
  always_comb begin
    tdata = '0;
    tkeep = '0;
    for (int k = 0; k < WPB; k++) begin
      tdata[16*k +: 16] = word + 16'(k);
    end
    for (int i = 0; i < BPB; i++) begin
      tkeep[i] = !last || (LBW'(i) < last_bytes);
    end
  end

endmodule

// File: rtl/packet_gen.sv
// Streams a programmed burst of incrementing-pattern packets on AXI4-Stream.
// Latency: first TVALID one cycle after a qualified start; one beat per cycle.
// Backpressure: beats hold stable while TVALID & !TREADY; TVALID never withdrawn.
module packet_gen
  import packet_gen_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       packet_len,
  input  logic [31:0]       packet_count,
  input  logic [15:0]       idle_cycles,
  input  logic [15:0]       initial_value,
  input  logic              start,
  output logic              busy,
  output logic [DW-1:0]     AXIS_TDATA,
  output logic [DW/8-1:0]   AXIS_TKEEP,
  output logic              AXIS_TLAST,
  output logic              AXIS_TVALID,
  input  logic              AXIS_TREADY
);

  localparam int BPB = DW / 8;
  localparam int WPB = DW / 16;
  localparam int LBW = $clog2(BPB) + 1;

  state_t        state;
  logic [15:0]   len_r;
  logic [31:0]   count_r;
  logic [15:0]   idle_r;
  logic [15:0]   gap_cnt;
  logic [15:0]   word_nxt;     // first word of the next beat to be loaded
  logic [16:0]   beat_idx;     // index within the packet of the beat on the bus
  logic [31:0]   pkt_sent;

  logic          start_ok;
  logic [15:0]   len_sel;
  logic [16:0]   beats_total;
  logic [LBW-1:0] last_bytes;
  logic [16:0]   load_idx;
  logic [15:0]   fill_word;
  logic          fill_last;
  logic [DW-1:0] fill_tdata;
  logic [BPB-1:0] fill_tkeep;
  logic [31:0]   pkt_sent_inc;

  assign start_ok = start && (packet_count != 32'd0) && (packet_len != 16'd0) &&
                    (packet_len <= 16'(MAX_LEN));
  assign pkt_sent_inc = pkt_sent + 32'd1;

  // Select what the next loaded beat is: first beat of a run uses the live inputs,
  // otherwise the latched length and the running word.
  always_comb begin
    len_sel     = (state == IDLE) ? packet_len : len_r;
    beats_total = 17'((32'(len_sel) + 32'(BPB - 1)) / 32'(BPB));
    last_bytes  = LBW'(32'(len_sel) - (32'(beats_total) - 32'd1) * 32'(BPB));
    load_idx    = 17'd0;
    fill_word   = word_nxt;
    if (state == IDLE) begin
      fill_word = initial_value;
    end else if (state == SEND && !AXIS_TLAST) begin
      load_idx = beat_idx + 17'd1;
    end
    fill_last = (load_idx == beats_total - 17'd1);
  end

  packet_gen_fill #(.DW(DW)) u_fill (
    .word       (fill_word),
    .last       (fill_last),
    .last_bytes (last_bytes),
    .tdata      (fill_tdata),
    .tkeep      (fill_tkeep)
  );

  // Run control: latch config, advance beats on handshakes, insert idle gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      AXIS_TVALID <= 1'b0;
      AXIS_TLAST  <= 1'b0;
      AXIS_TDATA  <= '0;
      AXIS_TKEEP  <= '0;
      len_r       <= '0;
      count_r     <= '0;
      idle_r      <= '0;
      gap_cnt     <= '0;
      word_nxt    <= '0;
      beat_idx    <= '0;
      pkt_sent    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_r       <= packet_len;
            count_r     <= packet_count;
            idle_r      <= idle_cycles;
            word_nxt    <= initial_value + 16'(WPB);
            beat_idx    <= 17'd0;
            pkt_sent    <= 32'd0;
            AXIS_TDATA  <= fill_tdata;
            AXIS_TKEEP  <= fill_tkeep;
            AXIS_TLAST  <= fill_last;
            AXIS_TVALID <= 1'b1;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (AXIS_TREADY) begin
            if (!AXIS_TLAST) begin
              AXIS_TDATA <= fill_tdata;
              AXIS_TKEEP <= fill_tkeep;
              AXIS_TLAST <= fill_last;
              beat_idx   <= load_idx;
              word_nxt   <= word_nxt + 16'(WPB);
            end else begin
              pkt_sent <= pkt_sent_inc;
              if (pkt_sent_inc == count_r) begin
                AXIS_TVALID <= 1'b0;
                AXIS_TLAST  <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
              end else if (idle_r == 16'd0) begin
                AXIS_TDATA <= fill_tdata;
                AXIS_TKEEP <= fill_tkeep;
                AXIS_TLAST <= fill_last;
                beat_idx   <= 17'd0;
                word_nxt   <= word_nxt + 16'(WPB);
              end else begin
                AXIS_TVALID <= 1'b0;
                AXIS_TLAST  <= 1'b0;
                gap_cnt     <= idle_r;
                state       <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd1) begin
            AXIS_TDATA  <= fill_tdata;
            AXIS_TKEEP  <= fill_tkeep;
            AXIS_TLAST  <= fill_last;
            AXIS_TVALID <= 1'b1;
            beat_idx    <= 17'd0;
            word_nxt    <= word_nxt + 16'(WPB);
            state       <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
// Bench for packet_gen: randomized configs against a packet-level reference model.
// Latency: n/a.
// Backpressure: TREADY optionally randomized each cycle.
module tb_packet_gen;

  localparam int DW  = 512;
  localparam int BPB = DW / 8;
  localparam int WPB = DW / 16;

  logic           clk;
  logic           reset;
  logic [15:0]    packet_len;
  logic [31:0]    packet_count;
  logic [15:0]    idle_cycles;
  logic [15:0]    initial_value;
  logic           start;
  logic           busy;
  logic [DW-1:0]  AXIS_TDATA;
  logic [BPB-1:0] AXIS_TKEEP;
  logic           AXIS_TLAST;
  logic           AXIS_TVALID;
  logic           AXIS_TREADY;

  packet_gen #(.DW(DW), .MAX_LEN(9600)) dut (
    .clk           (clk),
    .reset         (reset),
    .packet_len    (packet_len),
    .packet_count  (packet_count),
    .idle_cycles   (idle_cycles),
    .initial_value (initial_value),
    .start         (start),
    .busy          (busy),
    .AXIS_TDATA    (AXIS_TDATA),
    .AXIS_TKEEP    (AXIS_TKEEP),
    .AXIS_TLAST    (AXIS_TLAST),
    .AXIS_TVALID   (AXIS_TVALID),
    .AXIS_TREADY   (AXIS_TREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int start_ref = 0;
  bit rdy_rand = 0;

  // capture side (written only by the negedge monitor)
  int             cyc = 0;
  logic [DW-1:0]  cap_data[$];
  logic [BPB-1:0] cap_keep[$];
  logic           cap_last[$];
  int             cap_cyc[$];
  int             stall_err = 0;
  int             idle_low = 0;
  int             busy_fall_cyc = -1;
  bit             prev_stall = 0;
  bit             prev_busy = 0;
  logic [DW-1:0]  prev_data;
  logic [BPB-1:0] prev_keep;
  logic           prev_last;

  // expected beats (written only by the main sequence)
  logic [DW-1:0]  exp_data[$];
  logic [BPB-1:0] exp_keep[$];
  logic           exp_last[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      AXIS_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: record handshakes, stall stability, idle cycles inside a run, busy fall.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_stall) begin
      if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== prev_data ||
          AXIS_TKEEP !== prev_keep || AXIS_TLAST !== prev_last)
        stall_err = stall_err + 1;
    end
    if (AXIS_TVALID === 1'b1 && AXIS_TREADY === 1'b1) begin
      cap_data.push_back(AXIS_TDATA);
      cap_keep.push_back(AXIS_TKEEP);
      cap_last.push_back(AXIS_TLAST);
      cap_cyc.push_back(cyc);
    end
    if (busy === 1'b1 && AXIS_TVALID !== 1'b1) idle_low = idle_low + 1;
    if (prev_busy && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy  = (busy === 1'b1);
    prev_stall = (AXIS_TVALID === 1'b1 && AXIS_TREADY !== 1'b1);
    prev_data  = AXIS_TDATA;
    prev_keep  = AXIS_TKEEP;
    prev_last  = AXIS_TLAST;
  end

  // Reference: the whole run is one continuous stream of 16-bit words starting at init.
  function automatic logic [DW-1:0] pattern(input logic [15:0] w);
    logic [DW-1:0] d;
    for (int k = 0; k < WPB; k++) d[16*k +: 16] = w + 16'(k);
    return d;
  endfunction

  task automatic model(input int len, input int count, input logic [15:0] init);
    int nbeats;
    int rem;
    logic [BPB-1:0] ones;
    logic [15:0] w;
    exp_data.delete();
    exp_keep.delete();
    exp_last.delete();
    nbeats = (len + BPB - 1) / BPB;
    rem = (len % BPB == 0) ? BPB : len % BPB;
    ones = '1;
    w = init;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < nbeats; b++) begin
        exp_data.push_back(pattern(w));
        exp_keep.push_back((b == nbeats - 1) ? (ones >> (BPB - rem)) : ones);
        exp_last.push_back(b == nbeats - 1);
        w = w + 16'(WPB);
      end
    end
  endtask

  task automatic do_start(input int len, input int cnt, input int idl, input logic [15:0] init);
    @(posedge clk);
    #1;
    packet_len    = 16'(len);
    packet_count  = 32'(cnt);
    idle_cycles   = 16'(idl);
    initial_value = init;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_ref = cyc + 1;
    packet_len    = 16'($urandom);
    packet_count  = $urandom;
    idle_cycles   = 16'($urandom);
    initial_value = 16'($urandom);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset tvalid: got %b want 0", AXIS_TVALID); end
    n_checks++; if (AXIS_TLAST !== 1'b0) begin n_fail++; $display("FAIL reset tlast: got %b want 0", AXIS_TLAST); end
    n_checks++; if (AXIS_TDATA !== '0) begin n_fail++; $display("FAIL reset tdata: got %h want 0", AXIS_TDATA); end
    n_checks++; if (AXIS_TKEEP !== '0) begin n_fail++; $display("FAIL reset tkeep: got %h want 0", AXIS_TKEEP); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    int base = cap_data.size();
    int il0 = idle_low;
    model(256, 2, 16'h0000);
    do_start(256, 2, 1, 16'h0000);
    wait_idle(200);
    n_checks++;
    if (cap_data.size() - base !== 8) begin
      n_fail++; $display("FAIL defaults beats: got %0d want 8", cap_data.size() - base);
    end
    for (int i = 0; i < exp_data.size() && base + i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[base+i] !== exp_data[i] || cap_keep[base+i] !== exp_keep[i] || cap_last[base+i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL defaults beat %0d: data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                 i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    if (cap_data.size() - base == 8) begin
      n_checks++;
      if (cap_cyc[base] !== start_ref) begin
        n_fail++; $display("FAIL defaults latency: first beat cycle %0d want %0d", cap_cyc[base], start_ref);
      end
      n_checks++;
      if (busy_fall_cyc !== cap_cyc[base+7] + 1) begin
        n_fail++; $display("FAIL defaults busy_fall: cycle %0d want %0d", busy_fall_cyc, cap_cyc[base+7] + 1);
      end
    end
    n_checks++;
    if (idle_low - il0 !== 1) begin
      n_fail++; $display("FAIL defaults gap: %0d idle cycles want 1", idle_low - il0);
    end
  endtask

  task automatic test_short();
    int lens[2] = '{65, 64};
    int want_beats[2] = '{2, 1};
    for (int t = 0; t < 2; t++) begin
      int base = cap_data.size();
      logic [15:0] init = 16'($urandom);
      model(lens[t], 1, init);
      do_start(lens[t], 1, 0, init);
      wait_idle(100);
      n_checks++;
      if (cap_data.size() - base !== want_beats[t]) begin
        n_fail++; $display("FAIL short len=%0d beats: got %0d want %0d", lens[t], cap_data.size() - base, want_beats[t]);
      end
      for (int i = 0; i < exp_data.size() && base + i < cap_data.size(); i++) begin
        n_checks++;
        if (cap_data[base+i] !== exp_data[i] || cap_keep[base+i] !== exp_keep[i] || cap_last[base+i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL short len=%0d beat %0d: data=%h keep=%h last=%b, want data=%h keep=%h last=%b", lens[t],
                   i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], exp_data[i], exp_keep[i], exp_last[i]);
        end
      end
      if (t == 0 && cap_data.size() - base == 2) begin
        n_checks++;
        if (cap_keep[base+1] !== 64'h1 || cap_last[base+1] !== 1'b1) begin
          n_fail++; $display("FAIL short tail: keep=%h last=%b want keep=1 last=1", cap_keep[base+1], cap_last[base+1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base = cap_data.size();
    logic [DW-1:0] d;
    model(64, 1, 16'hFFF0);
    do_start(64, 1, 0, 16'hFFF0);
    wait_idle(100);
    n_checks++;
    if (cap_data.size() - base !== 1) begin
      n_fail++; $display("FAIL wrap beats: got %0d want 1", cap_data.size() - base);
    end else begin
      d = cap_data[base];
      n_checks++;
      if (d[15:0] !== 16'hFFF0 || d[255:240] !== 16'hFFFF || d[271:256] !== 16'h0000 || d[511:496] !== 16'h000F) begin
        n_fail++; $display("FAIL wrap words: w0=%h w15=%h w16=%h w31=%h want fff0 ffff 0000 000f",
                           d[15:0], d[255:240], d[271:256], d[511:496]);
      end
      n_checks++;
      if (d !== exp_data[0]) begin
        n_fail++; $display("FAIL wrap data: got %h want %h", d, exp_data[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base = cap_data.size();
    int se0 = stall_err;
    int il0 = idle_low;
    rdy_rand = 1;
    model(128, 3, 16'h1234);
    do_start(128, 3, 0, 16'h1234);
    wait_idle(500);
    rdy_rand = 0;
    n_checks++;
    if (cap_data.size() - base !== 6) begin
      n_fail++; $display("FAIL bp beats: got %0d want 6", cap_data.size() - base);
    end
    for (int i = 0; i < exp_data.size() && base + i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[base+i] !== exp_data[i] || cap_keep[base+i] !== exp_keep[i] || cap_last[base+i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL bp beat %0d: data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                 i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    n_checks++;
    if (stall_err - se0 !== 0) begin
      n_fail++; $display("FAIL bp stability: %0d unstable stall cycles want 0", stall_err - se0);
    end
    n_checks++;
    if (idle_low - il0 !== 0) begin
      n_fail++; $display("FAIL bp gaps: %0d TVALID-low cycles in run want 0", idle_low - il0);
    end
  endtask

  task automatic test_start_ignored();
    int base = cap_data.size();
    int lens[3] = '{128, 0, 9601};
    int cnts[3] = '{0, 1, 1};
    model(128, 2, 16'h0100);
    do_start(128, 2, 1, 16'h0100);
    @(posedge clk); #1;
    packet_len = 16'd640; packet_count = 32'd5; idle_cycles = 16'd0; initial_value = 16'h7777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(200);
    n_checks++;
    if (cap_data.size() - base !== 4) begin
      n_fail++; $display("FAIL ignore midrun beats: got %0d want 4", cap_data.size() - base);
    end
    for (int i = 0; i < exp_data.size() && base + i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[base+i] !== exp_data[i] || cap_last[base+i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL ignore midrun beat %0d: data=%h last=%b want data=%h last=%b",
                 i, cap_data[base+i], cap_last[base+i], exp_data[i], exp_last[i]);
      end
    end
    for (int t = 0; t < 3; t++) begin
      int b2 = cap_data.size();
      bit saw_busy = 0;
      do_start(lens[t], cnts[t], 0, 16'h0);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (busy !== 1'b0) saw_busy = 1;
      end
      n_checks++;
      if (saw_busy || cap_data.size() !== b2) begin
        n_fail++; $display("FAIL ignore len=%0d cnt=%0d: busy seen=%0d beats=%0d want 0 0",
                           lens[t], cnts[t], saw_busy, cap_data.size() - b2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [15:0] init = 16'($urandom);
    do_start(256, 1, 0, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (AXIS_TVALID !== 1'b0 || busy !== 1'b0 || AXIS_TLAST !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: tvalid=%b busy=%b tlast=%b want 0 0 0", AXIS_TVALID, busy, AXIS_TLAST);
    end
    base = cap_data.size();
    model(64, 1, init);
    do_start(64, 1, 0, init);
    wait_idle(100);
    n_checks++;
    if (cap_data.size() - base !== 1 || cap_data[base] !== exp_data[0] || cap_last[base] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid restart: beats=%0d data=%h want 1 beat data=%h",
                         cap_data.size() - base, cap_data[base], exp_data[0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int base = cap_data.size();
      int se0 = stall_err;
      int il0 = idle_low;
      int len = $urandom_range(1, 300);
      int cnt = $urandom_range(1, 3);
      int idl = $urandom_range(0, 3);
      logic [15:0] init = 16'($urandom);
      rdy_rand = 1;
      model(len, cnt, init);
      do_start(len, cnt, idl, init);
      wait_idle(2000);
      rdy_rand = 0;
      n_checks++;
      if (cap_data.size() - base !== exp_data.size()) begin
        n_fail++; $display("FAIL random %0d beats: got %0d want %0d", r, cap_data.size() - base, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && base + i < cap_data.size(); i++) begin
        n_checks++;
        if (cap_data[base+i] !== exp_data[i] || cap_keep[base+i] !== exp_keep[i] || cap_last[base+i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL random %0d (len=%0d) beat %0d: data=%h keep=%h last=%b, want data=%h keep=%h last=%b", r, len,
                   i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], exp_data[i], exp_keep[i], exp_last[i]);
        end
      end
      n_checks++;
      if (stall_err - se0 !== 0 || idle_low - il0 !== idl * (cnt - 1)) begin
        n_fail++; $display("FAIL random %0d flow: unstable=%0d gaps=%0d want 0 and %0d",
                           r, stall_err - se0, idle_low - il0, idl * (cnt - 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    packet_len = 16'd0;
    packet_count = 32'd0;
    idle_cycles = 16'd0;
    initial_value = 16'd0;
    test_reset();
    test_defaults();
    test_short();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
